// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, instruction
// classes, opcode/funct constants, operation selects and the control bundle.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM       = 3'd3,
    S_MULT_WAIT = 3'd4,
    S_WB        = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_ALU, CL_BRANCH, CL_J, CL_JR, CL_LW, CL_SW, CL_MULT
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4, ALU_NOR = 3'd5, ALU_SLT = 3'd6;
  localparam logic [1:0] SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2;
  localparam logic [2:0] CMP_EQ = 3'b000, CMP_NE = 3'b101, CMP_LEZ = 3'b010, CMP_GTZ = 3'b011;
  localparam logic [1:0] PC_SEQ = 2'b00, PC_REG = 2'b01, PC_JUMP = 2'b10;

  typedef struct packed {
    iclass_t    cls;
    logic [2:0] aluop;
    logic [1:0] shiftop;
    logic       selimregb;
    logic       selalushift;
    logic       unsig;
    logic       selregdest;
    logic [2:0] compop;
    logic       signed_ov;
  } dec_t;

  typedef struct packed {
    logic       instr_ready;
    logic       pcinc;
    logic       pcwrite;
    logic       pcwritecond;
    logic       writereg;
    logic       writehilo;
    logic       readmem;
    logic       writemem;
    logic       selwsource;
    logic       selregdest;
    logic       selimregb;
    logic       selalushift;
    logic       unsig;
    logic       exception;
    logic [2:0] aluop;
    logic [1:0] shiftop;
    logic [2:0] compop;
    logic [1:0] selpctype;
  } ctl_t;

endpackage

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational opcode/funct -> instruction class and operation selects.
// Zero latency; no flow control, fed from the latched instruction.
module multicycle_control_instr_class_decode
  import multicycle_control_pkg::*;
#(
  parameter int ENABLE_MULT = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.selregdest = 1'b1;
        dec.cls        = CL_ALU;
        case (funct)
          FN_ADD:  begin dec.aluop = ALU_ADD; dec.signed_ov = 1'b1; end
          FN_ADDU: begin dec.aluop = ALU_ADD; dec.unsig = 1'b1; end
          FN_SUB:  begin dec.aluop = ALU_SUB; dec.signed_ov = 1'b1; end
          FN_SUBU: begin dec.aluop = ALU_SUB; dec.unsig = 1'b1; end
          FN_AND:  dec.aluop = ALU_AND;
          FN_OR:   dec.aluop = ALU_OR;
          FN_XOR:  dec.aluop = ALU_XOR;
          FN_NOR:  dec.aluop = ALU_NOR;
          FN_SLT:  dec.aluop = ALU_SLT;
          FN_SLTU: begin dec.aluop = ALU_SLT; dec.unsig = 1'b1; end
          FN_SLL:  begin dec.selalushift = 1'b1; dec.shiftop = SH_SLL; end
          FN_SRL:  begin dec.selalushift = 1'b1; dec.shiftop = SH_SRL; end
          FN_SRA:  begin dec.selalushift = 1'b1; dec.shiftop = SH_SRA; end
          FN_JR:   dec.cls = CL_JR;
          FN_MULT: dec.cls = (ENABLE_MULT != 0) ? CL_MULT : CL_ILLEGAL;
          default: dec.cls = CL_ILLEGAL;
        endcase
      end
      OP_J:     dec.cls = CL_J;
      OP_BEQ:   begin dec.cls = CL_BRANCH; dec.aluop = ALU_SUB; dec.compop = CMP_EQ;  end
      OP_BNE:   begin dec.cls = CL_BRANCH; dec.aluop = ALU_SUB; dec.compop = CMP_NE;  end
      OP_BLEZ:  begin dec.cls = CL_BRANCH; dec.aluop = ALU_SUB; dec.compop = CMP_LEZ; end
      OP_BGTZ:  begin dec.cls = CL_BRANCH; dec.aluop = ALU_SUB; dec.compop = CMP_GTZ; end
      OP_ADDI:  begin dec.cls = CL_ALU; dec.aluop = ALU_ADD; dec.selimregb = 1'b1; dec.signed_ov = 1'b1; end
      OP_ADDIU: begin dec.cls = CL_ALU; dec.aluop = ALU_ADD; dec.selimregb = 1'b1; dec.unsig = 1'b1; end
      OP_SLTI:  begin dec.cls = CL_ALU; dec.aluop = ALU_SLT; dec.selimregb = 1'b1; end
      // logical immediates are zero-extended
      OP_ANDI:  begin dec.cls = CL_ALU; dec.aluop = ALU_AND; dec.selimregb = 1'b1; dec.unsig = 1'b1; end
      OP_ORI:   begin dec.cls = CL_ALU; dec.aluop = ALU_OR;  dec.selimregb = 1'b1; dec.unsig = 1'b1; end
      OP_LW:    begin dec.cls = CL_LW; dec.aluop = ALU_ADD; dec.selimregb = 1'b1; end
      OP_SW:    begin dec.cls = CL_SW; dec.aluop = ALU_ADD; dec.selimregb = 1'b1; end
      default:  dec.cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/MULT_WAIT/WB/TRAP.
// Accept-to-ready 3..5 cycles plus memory waits / MULT latency; instr_ready only in FETCH, MEM holds until mem_ready.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int ENABLE_MULT = 1,
  parameter int TRAP_ON_OV  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       ov,
  output logic       pcinc,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       writereg,
  output logic       writehilo,
  output logic       readmem,
  output logic       writemem,
  output logic       selwsource,
  output logic       selregdest,
  output logic       selimregb,
  output logic       selalushift,
  output logic       unsig,
  output logic [2:0] aluop,
  output logic [1:0] shiftop,
  output logic [2:0] compop,
  output logic [1:0] selpctype,
  output logic       exception,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(MULT_CYCLES + 1);

  state_t        state, state_nx;
  logic [5:0]    op_q, fn_q;
  logic          ov_q;
  logic [CW-1:0] cnt;
  dec_t          dec;
  ctl_t          ctl_q, ctl_o;
  logic          ovbad_q, ovbad_nx;

  multicycle_control_instr_class_decode #(.ENABLE_MULT(ENABLE_MULT)) u_decode (
    .opcode(op_q),
    .funct (fn_q),
    .dec   (dec)
  );

  // ovbad_nx sees the live ov during EXEC so the registered WB bundle is right on entry
  assign ovbad_q  = dec.signed_ov & ov_q;
  assign ovbad_nx = dec.signed_ov & ((state == S_EXEC) ? ov : ov_q);

  function automatic ctl_t ctl_for(state_t s, dec_t d, logic ovbad);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  c.instr_ready = 1'b1;
      S_DECODE: c.pcinc = 1'b1;
      S_EXEC: begin
        case (d.cls)
          CL_ALU: begin
            c.aluop       = d.aluop;
            c.shiftop     = d.shiftop;
            c.selimregb   = d.selimregb;
            c.selalushift = d.selalushift;
            c.unsig       = d.unsig;
          end
          CL_J:      begin c.pcwrite = 1'b1; c.selpctype = PC_JUMP; end
          CL_JR:     begin c.pcwrite = 1'b1; c.selpctype = PC_REG;  end
          CL_BRANCH: begin c.pcwritecond = 1'b1; c.compop = d.compop; c.aluop = d.aluop; end
          CL_LW, CL_SW: begin c.aluop = d.aluop; c.selimregb = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        c.readmem  = (d.cls == CL_LW);
        c.writemem = (d.cls == CL_SW);
      end
      S_WB: begin
        if (d.cls == CL_MULT) begin
          c.writehilo = 1'b1;
        end else begin
          c.writereg   = ~ovbad;
          c.selwsource = (d.cls == CL_LW);
          c.selregdest = d.selregdest;
        end
      end
      S_TRAP:  c.exception = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (instr_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = (dec.cls == CL_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (dec.cls)
          CL_ALU:       state_nx = S_WB;
          CL_LW, CL_SW: state_nx = S_MEM;
          CL_MULT:      state_nx = (MULT_CYCLES == 1) ? S_WB : S_MULT_WAIT;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEM:       if (mem_ready) state_nx = (dec.cls == CL_LW) ? S_WB : S_FETCH;
      S_MULT_WAIT: if (cnt == CW'(1)) state_nx = S_WB;
      S_WB:        state_nx = (ovbad_q && (TRAP_ON_OV != 0)) ? S_TRAP : S_FETCH;
      S_TRAP:      state_nx = S_TRAP;
      default:     state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
      fn_q  <= '0;
      ov_q  <= 1'b0;
      cnt   <= '0;
      ctl_q <= ctl_for(S_FETCH, '0, 1'b0);
    end else begin
      state <= state_nx;
      ctl_q <= ctl_for(state_nx, dec, ovbad_nx);
      if (state == S_FETCH && instr_valid) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (state == S_EXEC) ov_q <= ov;
      if (state == S_EXEC && dec.cls == CL_MULT) cnt <= CW'(MULT_CYCLES - 1);
      else if (state == S_MULT_WAIT)             cnt <= cnt - 1'b1;
    end
  end

  assign ctl_o       = reset ? '0 : ctl_q;
  assign state_o     = reset ? 3'd0 : state;
  assign instr_ready = ctl_o.instr_ready;
  assign pcinc       = ctl_o.pcinc;
  assign pcwrite     = ctl_o.pcwrite;
  assign pcwritecond = ctl_o.pcwritecond;
  assign writereg    = ctl_o.writereg;
  assign writehilo   = ctl_o.writehilo;
  assign readmem     = ctl_o.readmem;
  assign writemem    = ctl_o.writemem;
  assign selwsource  = ctl_o.selwsource;
  assign selregdest  = ctl_o.selregdest;
  assign selimregb   = ctl_o.selimregb;
  assign selalushift = ctl_o.selalushift;
  assign unsig       = ctl_o.unsig;
  assign exception   = ctl_o.exception;
  assign aluop       = ctl_o.aluop;
  assign shiftop     = ctl_o.shiftop;
  assign compop      = ctl_o.compop;
  assign selpctype   = ctl_o.selpctype;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance runs with MULT disabled
// and overflow traps off so both parameter branches see the same stimulus.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0;
  logic mem_ready = 1'b0;
  logic ov = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;

  logic instr_ready, pcinc, pcwrite, pcwritecond, writereg, writehilo, readmem, writemem;
  logic selwsource, selregdest, selimregb, selalushift, unsig, exception;
  logic [2:0] aluop, compop, state_o;
  logic [1:0] shiftop, selpctype;

  logic b_instr_ready, b_pcinc, b_pcwrite, b_pcwritecond, b_writereg, b_writehilo, b_readmem, b_writemem;
  logic b_selwsource, b_selregdest, b_selimregb, b_selalushift, b_unsig, b_exception;
  logic [2:0] b_aluop, b_compop, b_state_o;
  logic [1:0] b_shiftop, b_selpctype;

  int n_tests = 0;
  int n_fail = 0;

  wire [26:0] all_out = {instr_ready, pcinc, pcwrite, pcwritecond, writereg, writehilo, readmem,
                         writemem, selwsource, selregdest, selimregb, selalushift, unsig, exception,
                         aluop, shiftop, compop, selpctype, state_o};

  multicycle_control #(.MULT_CYCLES(4), .ENABLE_MULT(1), .TRAP_ON_OV(1)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .mem_ready(mem_ready), .ov(ov),
    .pcinc(pcinc), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .writereg(writereg),
    .writehilo(writehilo), .readmem(readmem), .writemem(writemem), .selwsource(selwsource),
    .selregdest(selregdest), .selimregb(selimregb), .selalushift(selalushift), .unsig(unsig),
    .aluop(aluop), .shiftop(shiftop), .compop(compop), .selpctype(selpctype),
    .exception(exception), .state_o(state_o)
  );

  multicycle_control #(.MULT_CYCLES(4), .ENABLE_MULT(0), .TRAP_ON_OV(0)) dut2 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(b_instr_ready),
    .opcode(opcode), .funct(funct), .mem_ready(mem_ready), .ov(ov),
    .pcinc(b_pcinc), .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond), .writereg(b_writereg),
    .writehilo(b_writehilo), .readmem(b_readmem), .writemem(b_writemem), .selwsource(b_selwsource),
    .selregdest(b_selregdest), .selimregb(b_selimregb), .selalushift(b_selalushift), .unsig(b_unsig),
    .aluop(b_aluop), .shiftop(b_shiftop), .compop(b_compop), .selpctype(b_selpctype),
    .exception(b_exception), .state_o(b_state_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; ov = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic accept(input logic [5:0] op, input logic [5:0] fn);
    instr_valid = 1'b1; opcode = op; funct = fn;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++; if (all_out !== 27'd0) begin n_fail++; $display("FAIL reset_outputs_async got %h want 0", all_out); end
    tick();
    n_tests++; if (all_out !== 27'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", all_out); end
    reset = 1'b0;
    #1;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", instr_ready); end
    n_tests++; if (state_o !== 3'd0 || exception !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0d/%b want 0/0", state_o, exception); end
  endtask

  task automatic test_alu();
    do_reset();
    accept(6'h00, 6'h20);
    n_tests++; if (pcinc !== 1'b1 || state_o !== 3'd1) begin n_fail++; $display("FAIL add_decode got pcinc=%b st=%0d want 1/1", pcinc, state_o); end
    tick();
    n_tests++; if (state_o !== 3'd2 || aluop !== 3'd0 || unsig !== 1'b0 || pcinc !== 1'b0) begin n_fail++; $display("FAIL add_exec got st=%0d aluop=%0d unsig=%b pcinc=%b want 2/0/0/0", state_o, aluop, unsig, pcinc); end
    tick();
    n_tests++; if (writereg !== 1'b1 || selregdest !== 1'b1 || selwsource !== 1'b0) begin n_fail++; $display("FAIL add_wb got wr=%b rd=%b ws=%b want 1/1/0", writereg, selregdest, selwsource); end
    tick();
    n_tests++; if (instr_ready !== 1'b1 || writereg !== 1'b0) begin n_fail++; $display("FAIL add_ready got rdy=%b wr=%b want 1/0", instr_ready, writereg); end
    // unsigned add ignores ov
    accept(6'h00, 6'h21);
    tick();
    n_tests++; if (unsig !== 1'b1) begin n_fail++; $display("FAIL addu_unsig got %b want 1", unsig); end
    ov = 1'b1;
    tick();
    ov = 1'b0;
    n_tests++; if (writereg !== 1'b1) begin n_fail++; $display("FAIL addu_ov_write got %b want 1", writereg); end
    tick();
    n_tests++; if (state_o !== 3'd0 || exception !== 1'b0) begin n_fail++; $display("FAIL addu_ov_fetch got st=%0d exc=%b want 0/0", state_o, exception); end
  endtask

  task automatic test_lw();
    int cnt_rd;
    do_reset();
    accept(6'h23, 6'h00);
    tick();
    n_tests++; if (selimregb !== 1'b1 || aluop !== 3'd0 || readmem !== 1'b0) begin n_fail++; $display("FAIL lw_exec got imm=%b aluop=%0d rd=%b want 1/0/0", selimregb, aluop, readmem); end
    cnt_rd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (readmem === 1'b1) cnt_rd++;
      if (i == 3) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    n_tests++; if (cnt_rd != 4) begin n_fail++; $display("FAIL lw_readmem_cycles got %0d want 4", cnt_rd); end
    n_tests++; if (state_o !== 3'd5 || readmem !== 1'b0 || writereg !== 1'b1 || selwsource !== 1'b1) begin n_fail++; $display("FAIL lw_wb got st=%0d rd=%b wr=%b ws=%b want 5/0/1/1", state_o, readmem, writereg, selwsource); end
    tick();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready got %b want 1", instr_ready); end
  endtask

  task automatic test_ov_trap();
    int wr_seen;
    do_reset();
    accept(6'h00, 6'h20);
    wr_seen = 0;
    tick();
    ov = 1'b1;
    tick();
    ov = 1'b0;
    if (writereg === 1'b1) wr_seen++;
    n_tests++; if (b_writereg !== 1'b0 || b_state_o !== 3'd5) begin n_fail++; $display("FAIL ov_nowrite_silent got wr=%b st=%0d want 0/5", b_writereg, b_state_o); end
    tick();
    n_tests++; if (b_state_o !== 3'd0 || b_exception !== 1'b0) begin n_fail++; $display("FAIL ov_silent_fetch got st=%0d exc=%b want 0/0", b_state_o, b_exception); end
    instr_valid = 1'b1; opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 3; i++) begin
      if (writereg === 1'b1) wr_seen++;
      n_tests++; if (exception !== 1'b1 || state_o !== 3'd6 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL ov_trap_sticky got exc=%b st=%0d rdy=%b want 1/6/0", exception, state_o, instr_ready); end
      tick();
    end
    instr_valid = 1'b0;
    n_tests++; if (wr_seen != 0) begin n_fail++; $display("FAIL ov_writereg_seen got %0d want 0", wr_seen); end
  endtask

  task automatic test_mult();
    int lat, waits, hilo, wr;
    do_reset();
    accept(6'h00, 6'h18);
    tick();
    n_tests++; if (b_state_o !== 3'd6 || b_exception !== 1'b1) begin n_fail++; $display("FAIL mult_disabled_trap got st=%0d exc=%b want 6/1", b_state_o, b_exception); end
    lat = 2; waits = 0; hilo = 0; wr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lat++;
      if (state_o === 3'd4) waits++;
      if (writehilo === 1'b1) hilo++;
      if (writereg === 1'b1) wr++;
      if (instr_ready === 1'b1) break;
    end
    n_tests++; if (waits != 3) begin n_fail++; $display("FAIL mult_wait_cycles got %0d want 3", waits); end
    n_tests++; if (hilo != 1 || wr != 0) begin n_fail++; $display("FAIL mult_writes got hilo=%0d wr=%0d want 1/0", hilo, wr); end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL mult_latency got %0d want 7", lat); end
  endtask

  task automatic test_branch();
    do_reset();
    accept(6'h05, 6'h00);
    tick();
    n_tests++; if (pcwritecond !== 1'b1 || compop !== 3'b101 || state_o !== 3'd2) begin n_fail++; $display("FAIL bne_exec got pwc=%b cmp=%b st=%0d want 1/101/2", pcwritecond, compop, state_o); end
    tick();
    n_tests++; if (pcwritecond !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL bne_fetch got pwc=%b rdy=%b want 0/1", pcwritecond, instr_ready); end
    accept(6'h02, 6'h00);
    tick();
    n_tests++; if (pcwrite !== 1'b1 || selpctype !== 2'b10) begin n_fail++; $display("FAIL j_exec got pw=%b sel=%b want 1/10", pcwrite, selpctype); end
    tick();
    accept(6'h00, 6'h08);
    tick();
    n_tests++; if (pcwrite !== 1'b1 || selpctype !== 2'b01 || writereg !== 1'b0) begin n_fail++; $display("FAIL jr_exec got pw=%b sel=%b wr=%b want 1/01/0", pcwrite, selpctype, writereg); end
    tick();
    n_tests++; if (instr_ready !== 1'b1 || pcwrite !== 1'b0) begin n_fail++; $display("FAIL jr_fetch got rdy=%b pw=%b want 1/0", instr_ready, pcwrite); end
  endtask

  task automatic test_illegal();
    do_reset();
    accept(6'h3F, 6'h00);
    n_tests++; if (pcinc !== 1'b1) begin n_fail++; $display("FAIL illegal_decode got pcinc=%b want 1", pcinc); end
    tick();
    n_tests++; if (state_o !== 3'd6 || exception !== 1'b1 || pcinc !== 1'b0) begin n_fail++; $display("FAIL illegal_trap got st=%0d exc=%b pcinc=%b want 6/1/0", state_o, exception, pcinc); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    accept(6'h2B, 6'h00);
    tick(); tick(); tick();
    n_tests++; if (writemem !== 1'b1 || state_o !== 3'd3) begin n_fail++; $display("FAIL sw_mem_hold got wm=%b st=%0d want 1/3", writemem, state_o); end
    reset = 1'b1;
    tick();
    n_tests++; if (writemem !== 1'b0 || state_o !== 3'd0 || exception !== 1'b0) begin n_fail++; $display("FAIL reset_mid_mem got wm=%b st=%0d exc=%b want 0/0/0", writemem, state_o, exception); end
    reset = 1'b0;
    #1;
    n_tests++; if (instr_ready !== 1'b1 || writemem !== 1'b0) begin n_fail++; $display("FAIL reset_mid_mem_release got rdy=%b wm=%b want 1/0", instr_ready, writemem); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready = 1'b1; instr_valid = 1'b1; opcode = 6'h2B; funct = 6'h00;
    tick(); tick(); tick();
    n_tests++; if (writemem !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_mem got %b want 1", writemem); end
    tick();
    n_tests++; if (writemem !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_done got wm=%b rdy=%b want 0/1", writemem, instr_ready); end
    opcode = 6'h04;
    tick();
    instr_valid = 1'b0; mem_ready = 1'b0;
    tick();
    n_tests++; if (pcwritecond !== 1'b1 || compop !== 3'b000) begin n_fail++; $display("FAIL b2b_beq_exec got pwc=%b cmp=%b want 1/000", pcwritecond, compop); end
    tick();
    n_tests++; if (instr_ready !== 1'b1 || writemem !== 1'b0) begin n_fail++; $display("FAIL b2b_beq_fetch got rdy=%b wm=%b want 1/0", instr_ready, writemem); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_ov_trap();
    test_mult();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
